fifo_wr_arbiter: RTL

Round-robin write-port arbiter sharing the async FIFO's write side among NUM_REQ producers in the wr_clk domain. Grants one requester at a time for a burst of up to MAX_BURST beats, forwards accepted beats directly onto the FIFO's wr_en/data_in, and stalls on fifo_full without losing the grant. Sits between the producer blocks and async_fifo_top.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 48 ++++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   - state_e       : arbiter FSM states
//   - idx_width()   : width of a requester index (at least 1 bit)
//   - Def*          : default parameter values
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefMaxBurst  = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Selects the first asserted request at
//   or after (last_winner + 1) mod NUM_REQ.
//   Ports:
//     req          in   NUM_REQ  request vector
//     last_winner  in   IW       index of the previous winner
//     pick_onehot  out  NUM_REQ  one-hot winner (zero if no request)
//     pick_idx     out  IW       winner index (zero if no request)
//     pick_any     out  1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IW-1:0]      pick_idx,
    output logic               pick_any
);

    always_comb begin
        logic [NUM_REQ-1:0] req_shift;
        int                 idx;
        logic               found;
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        idx         = 0;
        req_shift   = '0;
        // Walk candidates starting one past the previous winner.
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx       = (int'(last_winner) + k) % int'(NUM_REQ);
            req_shift = req >> idx;
            if (!found && req_shift[0]) begin
                found       = 1'b1;
                pick_idx    = IW'(idx);
                pick_onehot = NUM_REQ'(1) << idx;
            end
        end
    end

    assign pick_any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing an async FIFO write port among NUM_REQ
//   producers. One requester is granted for a burst of up to MAX_BURST beats;
//   accepted beats go straight to wr_en/data_in. fifo_full stalls the burst
//   while keeping the grant.
//   Optional: define FIFO_WR_ARB_TAG_EN to overwrite the top idx_width bits
//   of data_in with the granted requester index.
//   Ports:
//     wr_clk     in   1                    write-domain clock
//     rst_n      in   1                    synchronous active-low reset
//     req_valid  in   NUM_REQ              requester has a beat
//     req_last   in   NUM_REQ              beat ends requester's burst
//     req_data   in   NUM_REQ*DATA_WIDTH   per-requester beat data
//     req_ready  out  NUM_REQ              beat accepted this cycle
//     grant      out  NUM_REQ              registered one-hot grant
//     busy       out  1                    grant active
//     fifo_full  in   1                    FIFO full flag
//     wr_en      out  1                    FIFO write strobe
//     data_in    out  DATA_WIDTH           FIFO write data
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned MAX_BURST  = DefMaxBurst
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               g_valid;
    logic               g_last;
    logic               beat;
    logic [DATA_WIDTH-1:0] g_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req         (req_valid),
        .last_winner (last_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    assign g_valid = req_valid[gidx_q];
    assign g_last  = req_last[gidx_q];
    assign g_data  = req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign beat    = (state_q == StGrant) && g_valid && !fifo_full;

    // Write-side outputs are purely combinational from registered grant.
    always_comb begin
        req_ready = '0;
        wr_en     = beat;
        data_in   = '0;
        if (beat) begin
            req_ready = grant_q;
`ifdef FIFO_WR_ARB_TAG_EN
            data_in   = {gidx_q, g_data[DATA_WIDTH-IW-1:0]};
`else
            data_in   = g_data;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == StGrant);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d    = pick_onehot;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (!g_valid) begin
                    // Requester went away: release without a beat.
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = StIdle;
                end else if (!fifo_full) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (g_last || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        last_d  = gidx_q;
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
                // fifo_full with valid request: hold everything.
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
